afifo_wr_arbiter: RTL and testbench
===================================

// Module: afifo_wr_arbiter
// PURPOSE
// - Shares the single write port of the async FIFO (wclk domain) among NREQ packet sources.
// - Round-robin arbitration at packet granularity: a granted source owns the port until its last beat.
// - A beat cap of MAX_BEATS forces release so one long packet cannot starve the others.
// - Sits directly in front of the FIFO write-pointer/full logic; drives winc/wdata, honours wfull.
// PARAMETERS
// - NREQ       4   number of requesters, >=2
// - DW         8   data width per beat
// - MAX_BEATS  16  beats per grant before forced release, >=1
// - CW         $clog2(NREQ) grant-id width (localparam)
// PORTS
// - wclk       in   1        write clock
// - wrst_n     in   1        reset, asynchronous, active-low
// - req_valid  in   NREQ     per-source beat valid
// - req_last   in   NREQ     per-source last beat of packet, qualified by req_valid
// - req_data   in   NREQ*DW  per-source data, source i at [i*DW +: DW]
// - req_ready  out  NREQ     per-source beat accepted this cycle
// - wfull      in   1        FIFO full, registered in the wclk domain
// - winc       out  1        FIFO write strobe
// - wdata      out  DW       FIFO write data
// - grant_id   out  CW       index of current owner; valid while busy=1
// - busy       out  1        a source currently owns the write port
// BEHAVIOUR
// - Reset values: state=IDLE, busy=0, grant_id=0, beat_cnt=0, rr_last=NREQ-1; so req_ready=0, winc=0.
// - FSM states IDLE, OWN.
// - IDLE: if any req_valid, pick the first valid index searching rr_last+1, +2, ... modulo NREQ;
//   register grant_id <= pick, rr_last <= pick, beat_cnt <= 0, state <= OWN. No beat moves in IDLE.
// - Arbitration latency: one cycle from req_valid high in IDLE to busy=1; first beat transfers
//   no earlier than the following cycle.
// - OWN: accept = req_valid[grant_id] & ~wfull (combinational on registered grant_id).
//   req_ready[grant_id] = ~wfull; every other req_ready bit = 0.
//   winc = accept; wdata = req_data[grant_id] (wdata is don't-care when winc=0).
// - Each accept: beat_cnt <= beat_cnt+1. Width: $clog2(MAX_BEATS+1) bits, never wraps.
// - Release: on accept with req_last[grant_id]=1, or on accept making beat_cnt reach MAX_BEATS,
//   state <= IDLE, busy <= 0 next cycle. Forced release resumes remaining beats of that source
//   as a new grant in normal round-robin order (packet may interleave; documented limitation).
// - Owner dropping req_valid mid-packet: port stays owned, winc=0; no timeout.
// - wfull=1: no accept, no counter change, grant held; wdata/req_data must be held by source.
// - Simultaneous release and new requests: one IDLE cycle always separates grants (no back-to-back
//   re-arbitration); new pick uses rr_last = just-released owner, so it goes last.
// - Single requester NREQ sources idle: same source may be re-granted after one IDLE cycle.
// - winc never asserts while wfull=1 (no overflow path exists in this block).
// - wrst_n assertion mid-packet: immediate return to reset values; partial packet is abandoned,
//   FIFO keeps beats already written.
// TESTING (NREQ=4, DW=8, MAX_BEATS=4)
// - Reset release, all req_valid=0 for 10 cycles -> busy=0, winc=0, req_ready=0000 throughout.
// - req_valid=1111, each source sends 2-beat packets data {i,0},{i,1} -> grants in order 0,1,2,3,0;
//   winc data sequence 00,01,10,11,20,21,30,31; one IDLE cycle between packets.
// - Source 2 sends 6-beat packet, others idle -> 4 beats accepted, busy drops, re-grant to 2 after
//   one IDLE cycle, last 2 beats written; total 6 winc pulses.
// - Source 1 owns, wfull=1 for 5 cycles mid-packet -> winc=0, req_ready[1]=0, grant_id=1 held,
//   beat_cnt unchanged; transfer resumes on first cycle wfull=0.
// - Source 3 last beat accepted while sources 0 and 3 valid -> next grant_id=0 (3 goes last).
// - wrst_n pulsed low while source 0 on beat 2 -> next cycle busy=0, winc=0, grant_id=0, rr_last=3;
//   after release, source 0 re-granted first.

Source files
------------

// File: rtl/afifo_wr_arbiter_if.sv
// Write-port bundle between the packet sources (master) and the FIFO write arbiter (slave).
interface afifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int CW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wfull;
  logic               winc;
  logic [DW-1:0]      wdata;
  logic [CW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter for the async FIFO write port; grant lands one cycle
// after request, beats then pass combinationally and stall while wfull is high.
module afifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic               wclk,
  input  logic               wrst_n,
  afifo_wr_arbiter_if.slave  bus
);
  localparam int CW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          r_state;
  logic            r_busy;
  logic [CW-1:0]   r_grant;
  logic [CW-1:0]   r_rr_last;
  logic [BW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_release;
  logic [CW-1:0]   w_pick;
  logic [BW-1:0]   w_cnt_nxt;

  // First valid source strictly after the previous owner, wrapping modulo NREQ.
  function automatic logic [CW-1:0] f_pick(input logic [NREQ-1:0] vld, input logic [CW-1:0] last);
    logic [CW-1:0] pick;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && vld[(int'(last) + k) % NREQ]) begin
        found = 1'b1;
        pick  = CW'((int'(last) + k) % NREQ);
      end
    end
    return pick;
  endfunction

  assign w_pick    = f_pick(bus.req_valid, r_rr_last);
  assign w_accept  = (r_state == OWN) & bus.req_valid[r_grant] & ~bus.wfull;
  assign w_cnt_nxt = r_cnt + BW'(1);
  assign w_release = w_accept & (bus.req_last[r_grant] | (w_cnt_nxt == BW'(MAX_BEATS)));

  assign bus.winc      = w_accept;
  assign bus.wdata     = bus.req_data[int'(r_grant) * DW +: DW];
  assign bus.req_ready = ((r_state == OWN) && !bus.wfull) ? (NREQ'(1) << r_grant) : '0;
  assign bus.grant_id  = r_grant;
  assign bus.busy      = r_busy;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_rr_last <= CW'(NREQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req_valid) begin
            r_grant   <= w_pick;
            r_rr_last <= w_pick;
            r_cnt     <= '0;
            r_state   <= OWN;
            r_busy    <= 1'b1;
          end
        end
        OWN: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            // A release always passes through IDLE, so the next pick sees rr_last = this owner.
            if (w_release) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_afifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int QD   = 64;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  afifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  afifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BEATS(MAXB)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Per-source pending beats: {last, data}
  logic [DW:0] smem [NREQ][QD];
  int shead [NREQ];
  int stail [NREQ];

  // Reference model: current owner (-1 = nobody), previous owner, beats this grant
  int m_owner = -1;
  int m_rr    = NREQ - 1;
  int m_cnt   = 0;

  int valid_pct = 100;
  int full_pct  = 0;
  logic prev_busy = 1'b0;
  int wlog[$];
  int glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int s, input int len, input int base);
    if (shead[s] == stail[s]) begin
      shead[s] = 0;
      stail[s] = 0;
    end
    for (int j = 0; j < len; j++) begin
      smem[s][stail[s]] = {(j == len - 1), 8'(base + j)};
      stail[s]++;
    end
  endtask

  function automatic bit all_empty();
    for (int s = 0; s < NREQ; s++)
      if (shead[s] != stail[s]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle();
    logic [NREQ-1:0]    v;
    logic [NREQ-1:0]    l;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    e_rdy;
    logic               f;
    logic               e_busy;
    logic               e_acc;
    logic               lst;
    @(negedge wclk);
    for (int s = 0; s < NREQ; s++) begin
      if (shead[s] < stail[s] && $urandom_range(99) < valid_pct) begin
        v[s] = 1'b1;
        {l[s], d[s*DW +: DW]} = smem[s][shead[s]];
      end else begin
        v[s] = 1'b0;
        l[s] = 1'($urandom);
        d[s*DW +: DW] = 8'($urandom);
      end
    end
    f = ($urandom_range(99) < full_pct);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.wfull     = f;
    #1;
    e_busy = (m_owner >= 0);
    e_acc  = 1'b0;
    e_rdy  = '0;
    if (e_busy) begin
      e_acc = v[m_owner] && !f;
      if (!f) e_rdy[m_owner] = 1'b1;
    end
    chk("busy",  32'(bus.busy),      32'(e_busy));
    chk("winc",  32'(bus.winc),      32'(e_acc));
    chk("ready", 32'(bus.req_ready), 32'(e_rdy));
    if (e_busy) chk("grant_id", 32'(bus.grant_id), m_owner);
    if (e_acc)  chk("wdata", 32'(bus.wdata), 32'(smem[m_owner][shead[m_owner]][DW-1:0]));
    if (bus.winc) wlog.push_back(int'(bus.wdata));
    if (bus.busy && !prev_busy) glog.push_back(int'(bus.grant_id));
    prev_busy = bus.busy;
    if (e_busy) begin
      if (e_acc) begin
        lst = smem[m_owner][shead[m_owner]][DW];
        shead[m_owner]++;
        m_cnt++;
        if (lst || m_cnt == MAXB) m_owner = -1;
      end
    end else if (v != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (v[(m_rr + k) % NREQ]) begin
          m_owner = (m_rr + k) % NREQ;
          break;
        end
      end
      m_rr  = m_owner;
      m_cnt = 0;
    end
  endtask

  task automatic run_until_idle(input string tag, input int maxc);
    int n = 0;
    while ((!all_empty() || m_owner >= 0) && n < maxc) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n < maxc), 32'd1);
  endtask

  task automatic run_until_head(input string tag, input int s, input int h, input int maxc);
    int n = 0;
    while (shead[s] < h && n < maxc) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n < maxc), 32'd1);
  endtask

  int base_w;

  initial begin
    for (int s = 0; s < NREQ; s++) begin
      shead[s] = 0;
      stail[s] = 0;
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;
    repeat (3) @(negedge wclk);
    #1;
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_winc",  32'(bus.winc),      32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_grant", 32'(bus.grant_id),  32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Idle after reset
    valid_pct = 0;
    repeat (10) cycle();

    // Four sources, 2-beat packets each, source 0 twice
    valid_pct = 100;
    wlog.delete();
    glog.delete();
    for (int s = 0; s < NREQ; s++) push_pkt(s, 2, s * 16);
    push_pkt(0, 2, 8'h50);
    run_until_idle("rr_drain", 100);
    chk("rr_nwrites", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      chk("rr_wdata", 32'(wlog[i]), 32'((i / 2) * 16 + (i % 2)));
    chk("rr_ngrants", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      chk("rr_order", 32'(glog[i]), 32'(i % NREQ));

    // Beat cap: 6-beat packet from source 2 alone
    wlog.delete();
    glog.delete();
    push_pkt(2, 6, 8'h40);
    run_until_idle("cap_drain", 100);
    chk("cap_nwrites", 32'(wlog.size()), 32'd6);
    chk("cap_ngrants", 32'(glog.size()), 32'd2);
    for (int i = 0; i < glog.size(); i++) chk("cap_owner", 32'(glog[i]), 32'd2);

    // wfull stall mid-packet on source 1
    push_pkt(1, 3, 8'h70);
    run_until_head("full_start", 1, 1, 20);
    full_pct = 100;
    base_w = wlog.size();
    repeat (5) cycle();
    chk("full_nowrite", 32'(wlog.size() - base_w), 32'd0);
    chk("full_grant", 32'(bus.grant_id), 32'd1);
    full_pct = 0;
    cycle();
    chk("full_resume", 32'(wlog.size() - base_w), 32'd1);
    run_until_idle("full_drain", 50);

    // Source 3 releases with 0 and 3 waiting: 3 goes last
    glog.delete();
    push_pkt(3, 1, 8'h31);
    push_pkt(3, 1, 8'h32);
    push_pkt(0, 1, 8'h01);
    run_until_idle("last_drain", 50);
    chk("last_ngrants", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      chk("last_g0", 32'(glog[0]), 32'd3);
      chk("last_g1", 32'(glog[1]), 32'd0);
      chk("last_g2", 32'(glog[2]), 32'd3);
    end

    // Reset mid-packet while source 0 owns the port
    push_pkt(0, 3, 8'h90);
    run_until_head("mrst_start", 0, 2, 20);
    @(negedge wclk);
    bus.req_valid = '0;
    wrst_n = 1'b0;
    #1;
    chk("mrst_busy",  32'(bus.busy),     32'd0);
    chk("mrst_winc",  32'(bus.winc),     32'd0);
    chk("mrst_grant", 32'(bus.grant_id), 32'd0);
    m_owner = -1;
    m_rr    = NREQ - 1;
    m_cnt   = 0;
    prev_busy = 1'b0;
    for (int s = 0; s < NREQ; s++) shead[s] = stail[s];
    @(negedge wclk);
    wrst_n = 1'b1;
    glog.delete();
    push_pkt(1, 1, 8'hA1);
    push_pkt(0, 1, 8'hA0);
    run_until_idle("mrst_drain", 50);
    chk("mrst_ngrants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) chk("mrst_first", 32'(glog[0]), 32'd0);

    // Randomized traffic with valid gaps and wfull stalls
    valid_pct = 70;
    full_pct  = 25;
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NREQ; s++)
        if (shead[s] == stail[s] && $urandom_range(3) == 0)
          push_pkt(s, $urandom_range(7, 1), int'($urandom_range(255)));
      cycle();
    end
    valid_pct = 100;
    full_pct  = 0;
    run_until_idle("rand_drain", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
